// File: rtl/if_id_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_id_fetch_unit
//
// Fetch PC register and IF/ID pipeline register of the 5-stage MIPS core.
// The next-PC logic hands in npc every cycle. This block registers npc as the
// fetch PC, captures the fetched word into ID, and supplies the ID-stage link
// values (PC+4 as the branch base, PC+8 as the jal link). It also owns stall
// hold, bubble insertion on flush and a count of accepted fetches.
//
// Edge priority: reset > stall > flush_id > normal advance.
//
// Ports
//   clk        in   1   core clock, rising edge
//   reset      in   1   synchronous active-high reset
//   npc        in  32   next fetch PC
//   stall      in   1   hold PC and IF/ID
//   flush_id   in   1   load a bubble into IF/ID (PC still advances)
//   instr_if   in  32   IM read data at pc_if
//   pc_if      out 32   fetch PC (IM address)
//   instr_id   out 32   instruction in ID (0 = sll nop when bubble)
//   pc_id      out 32   PC+4 of the ID instruction
//   pc8_id     out 32   PC+8 of the ID instruction
//   valid_id   out  1   ID holds a real fetched instruction
//   fetch_cnt  out 32   accepted fetches, wraps modulo 2^32
//   adel_id    out  1   ID instruction came from an illegal fetch address
//
// Optional feature macro: FETCH_ADDR_CHECK_EN
//   When defined, npc is checked for word alignment and for lying inside
//   [IM_BASE, IM_BASE+4*IM_WORDS). An illegal fetch still advances the PC with
//   its low bits cleared, but the instruction reaches ID as 0 with adel_id=1.
//   When undefined, adel_id is constant 0 and npc[1:0] is ignored.
// -----------------------------------------------------------------------------
module if_id_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] IM_BASE  = 32'h0000_3000,
   parameter int unsigned IM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] npc,
   input  logic        stall,
   input  logic        flush_id,
   input  logic [31:0] instr_if,
   output logic [31:0] pc_if,
   output logic [31:0] instr_id,
   output logic [31:0] pc_id,
   output logic [31:0] pc8_id,
   output logic        valid_id,
   output logic [31:0] fetch_cnt,
   output logic        adel_id
);

   // State registers
   logic [31:0] pc_r;
   logic [31:0] instr_id_r;
   logic [31:0] pc_id_r;
   logic [31:0] pc8_id_r;
   logic        valid_id_r;
   logic [31:0] fetch_cnt_r;
   logic        adel_id_r;

   // Next-state values
   logic [31:0] pc_nxt_s;
   logic [31:0] instr_id_nxt_s;
   logic [31:0] pc_id_nxt_s;
   logic [31:0] pc8_id_nxt_s;
   logic        valid_id_nxt_s;
   logic [31:0] fetch_cnt_nxt_s;
   logic        adel_id_nxt_s;

   // What a normal advance loads into ID (may be replaced by the address check)
   logic [31:0] adv_instr_s;
   logic        adv_adel_s;

   // PCs are always word aligned; the low bits of npc never reach pc_if.
   logic [31:0] npc_aligned_s;
   assign npc_aligned_s = {npc[31:2], 2'b00};

`ifdef FETCH_ADDR_CHECK_EN
   // One past the last legal byte address; 33 bits so a region ending at the
   // top of the address space does not wrap to zero.
   localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_WORDS) * 33'd4);

   logic npc_bad_s;
   logic bad_r;

   assign npc_bad_s = (npc[1:0] != 2'b00)
                   || ({1'b0, npc} <  {1'b0, IM_BASE})
                   || ({1'b0, npc} >= IM_LIMIT);

   // The legality flag travels with pc_if: loaded whenever the PC loads.
   always_ff @(posedge clk) begin
      if (reset) begin
         bad_r <= 1'b0;
      end else if (!stall) begin
         bad_r <= npc_bad_s;
      end else begin
         bad_r <= bad_r;
      end
   end

   // An illegal fetch delivers a nop to ID and raises the address-error flag.
   assign adv_instr_s = bad_r ? 32'd0 : instr_if;
   assign adv_adel_s  = bad_r;
`else
   assign adv_instr_s = instr_if;
   assign adv_adel_s  = 1'b0;

   // Parameters and npc low bits have no function without the address check.
   logic unused_s;
   assign unused_s = ^{IM_BASE, 32'(IM_WORDS), npc[1:0]};
`endif

   // Next-state selection for PC and IF/ID: stall holds, flush bubbles, else advance
   always_comb begin
      pc_nxt_s        = pc_r;
      instr_id_nxt_s  = instr_id_r;
      pc_id_nxt_s     = pc_id_r;
      pc8_id_nxt_s    = pc8_id_r;
      valid_id_nxt_s  = valid_id_r;
      fetch_cnt_nxt_s = fetch_cnt_r;
      adel_id_nxt_s   = adel_id_r;
      if (stall) begin
         // flush_id is deliberately ignored here; the requester keeps it high
         // until the stall drops, so the bubble is inserted then.
         pc_nxt_s        = pc_r;
         instr_id_nxt_s  = instr_id_r;
         valid_id_nxt_s  = valid_id_r;
         fetch_cnt_nxt_s = fetch_cnt_r;
      end else if (flush_id) begin
         pc_nxt_s        = npc_aligned_s;
         instr_id_nxt_s  = 32'd0;
         pc_id_nxt_s     = 32'd0;
         pc8_id_nxt_s    = 32'd0;
         valid_id_nxt_s  = 1'b0;
         adel_id_nxt_s   = 1'b0;
         fetch_cnt_nxt_s = fetch_cnt_r;
      end else begin
         pc_nxt_s        = npc_aligned_s;
         instr_id_nxt_s  = adv_instr_s;
         pc_id_nxt_s     = pc_r + 32'd4;
         pc8_id_nxt_s    = pc_r + 32'd8;
         valid_id_nxt_s  = 1'b1;
         adel_id_nxt_s   = adv_adel_s;
         fetch_cnt_nxt_s = fetch_cnt_r + 32'd1;
      end
   end

   // PC and IF/ID register bank; reset overrides stall and flush
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_r        <= RESET_PC;
         instr_id_r  <= 32'd0;
         pc_id_r     <= 32'd0;
         pc8_id_r    <= 32'd0;
         valid_id_r  <= 1'b0;
         fetch_cnt_r <= 32'd0;
         adel_id_r   <= 1'b0;
      end else begin
         pc_r        <= pc_nxt_s;
         instr_id_r  <= instr_id_nxt_s;
         pc_id_r     <= pc_id_nxt_s;
         pc8_id_r    <= pc8_id_nxt_s;
         valid_id_r  <= valid_id_nxt_s;
         fetch_cnt_r <= fetch_cnt_nxt_s;
         adel_id_r   <= adel_id_nxt_s;
      end
   end

   assign pc_if     = pc_r;
   assign instr_id  = instr_id_r;
   assign pc_id     = pc_id_r;
   assign pc8_id    = pc8_id_r;
   assign valid_id  = valid_id_r;
   assign fetch_cnt = fetch_cnt_r;
   assign adel_id   = adel_id_r;

endmodule

// File: tb/tb_if_id_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_id_fetch_unit
//
// Directed bench for if_id_fetch_unit. Instruction memory returns the word
// equal to its address. A reference model tracks which fetch address sits in
// ID and derives the expected outputs from it; a negedge process compares every
// output each cycle, and the directed sequence adds literal expectations.
// -----------------------------------------------------------------------------
module tb_if_id_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        flush_id;
   logic [31:0] npc;
   logic [31:0] instr_if;
   logic [31:0] pc_if;
   logic [31:0] instr_id;
   logic [31:0] pc_id;
   logic [31:0] pc8_id;
   logic        valid_id;
   logic [31:0] fetch_cnt;
   logic        adel_id;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   // Instruction memory: word content equals its byte address
   assign instr_if = pc_if;

   if_id_fetch_unit dut (
      .clk       (clk),
      .reset     (reset),
      .npc       (npc),
      .stall     (stall),
      .flush_id  (flush_id),
      .instr_if  (instr_if),
      .pc_if     (pc_if),
      .instr_id  (instr_id),
      .pc_id     (pc_id),
      .pc8_id    (pc8_id),
      .valid_id  (valid_id),
      .fetch_cnt (fetch_cnt),
      .adel_id   (adel_id)
   );

   // ---------------- reference model ----------------
   logic [31:0] m_pc;        // fetch address currently presented to IM
   logic        m_pc_bad;    // that address came from an illegal npc
   logic        m_valid;     // ID holds a fetched instruction
   logic [31:0] m_id_addr;   // fetch address of the instruction in ID
   logic        m_id_bad;    // that fetch was illegal
   logic [31:0] m_cnt;       // accepted fetches
   logic        chk_en = 1'b0;

   function automatic logic illegal(input logic [31:0] a);
`ifdef FETCH_ADDR_CHECK_EN
      return (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a >= 32'h0000_4000);
`else
      return 1'b0;
`endif
   endfunction

   // Model update on every edge from the same inputs the DUT sees
   always @(posedge clk) begin
      if (reset) begin
         m_pc      = 32'h0000_3000;
         m_pc_bad  = 1'b0;
         m_valid   = 1'b0;
         m_id_addr = 32'd0;
         m_id_bad  = 1'b0;
         m_cnt     = 32'd0;
         chk_en    = 1'b1;
      end else if (stall) begin
         m_cnt = m_cnt;
      end else if (flush_id) begin
         m_valid  = 1'b0;
         m_id_bad = 1'b0;
         m_pc     = npc & 32'hFFFF_FFFC;
         m_pc_bad = illegal(npc);
      end else begin
         m_valid   = 1'b1;
         m_id_addr = m_pc;
         m_id_bad  = m_pc_bad;
         m_cnt     = m_cnt + 32'd1;
         m_pc      = npc & 32'hFFFF_FFFC;
         m_pc_bad  = illegal(npc);
      end
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors = vectors + 1;
      if (act !== exp) begin
         miscompares = miscompares + 1;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare of all outputs against the model
   always @(negedge clk) begin
      if (chk_en) begin
         cmp("m.pc_if",     pc_if,     m_pc);
         cmp("m.instr_id",  instr_id,  (m_valid && !m_id_bad) ? m_id_addr : 32'd0);
         cmp("m.pc_id",     pc_id,     m_valid ? (m_id_addr + 32'd4) : 32'd0);
         cmp("m.pc8_id",    pc8_id,    m_valid ? (m_id_addr + 32'd8) : 32'd0);
         cmp("m.valid_id",  {31'd0, valid_id}, {31'd0, m_valid});
         cmp("m.fetch_cnt", fetch_cnt, m_cnt);
         cmp("m.adel_id",   {31'd0, adel_id},  {31'd0, m_valid & m_id_bad});
      end
   end

   task automatic step(input logic [31:0] n, input logic s, input logic f, input logic r);
      npc = n; stall = s; flush_id = f; reset = r;
      @(posedge clk);
      @(negedge clk);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      npc = 32'd0; stall = 1'b0; flush_id = 1'b0; reset = 1'b1;

      // reset
      step(32'd0, 1'b0, 1'b0, 1'b1);
      cmp("rst.pc_if", pc_if, 32'h0000_3000);
      cmp("rst.valid", {31'd0, valid_id}, 32'd0);
      cmp("rst.cnt",   fetch_cnt, 32'd0);
      cmp("rst.instr", instr_id, 32'd0);

      // sequential fetch
      step(32'h0000_3004, 1'b0, 1'b0, 1'b0);
      cmp("seq.pc_if", pc_if,    32'h0000_3004);
      cmp("seq.instr", instr_id, 32'h0000_3000);
      cmp("seq.pc_id", pc_id,    32'h0000_3004);
      cmp("seq.pc8",   pc8_id,   32'h0000_3008);
      cmp("seq.valid", {31'd0, valid_id}, 32'd1);
      cmp("seq.cnt",   fetch_cnt, 32'd1);
      step(32'h0000_3008, 1'b0, 1'b0, 1'b0);

      // stall for three edges with a pending jump target
      for (int i = 0; i < 3; i++) begin
         step(32'h0000_4000, 1'b1, 1'b0, 1'b0);
         cmp("stall.pc_if", pc_if,    32'h0000_3008);
         cmp("stall.instr", instr_id, 32'h0000_3004);
         cmp("stall.pc_id", pc_id,    32'h0000_3008);
         cmp("stall.cnt",   fetch_cnt, 32'd2);
      end
      step(32'h0000_4000, 1'b0, 1'b0, 1'b0);
      cmp("rel.pc_if", pc_if,    32'h0000_4000);
      cmp("rel.cnt",   fetch_cnt, 32'd3);

      // flush held off by stall, then applied
      step(32'h0000_4004, 1'b1, 1'b1, 1'b0);
      cmp("sf.pc_if", pc_if,    32'h0000_4000);
      cmp("sf.instr", instr_id, 32'h0000_3008);
      cmp("sf.valid", {31'd0, valid_id}, 32'd1);
      step(32'h0000_4004, 1'b0, 1'b1, 1'b0);
      cmp("fl.pc_if", pc_if,    32'h0000_4004);
      cmp("fl.instr", instr_id, 32'd0);
      cmp("fl.valid", {31'd0, valid_id}, 32'd0);
      cmp("fl.cnt",   fetch_cnt, 32'd3);

      // unaligned npc
      step(32'h0000_3010, 1'b0, 1'b0, 1'b0);
      step(32'h0000_3003, 1'b0, 1'b0, 1'b0);
      cmp("una.pc_if", pc_if, 32'h0000_3000);
      step(32'h0000_3014, 1'b0, 1'b0, 1'b0);
      cmp("una.pc_id", pc_id, 32'h0000_3004);
`ifdef FETCH_ADDR_CHECK_EN
      cmp("una.instr", instr_id, 32'd0);
      cmp("una.adel",  {31'd0, adel_id}, 32'd1);
`else
      cmp("una.instr", instr_id, 32'h0000_3000);
      cmp("una.adel",  {31'd0, adel_id}, 32'd0);
`endif

      // PC arithmetic wraps at the top of the address space
      step(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
      cmp("wrap.pc_if", pc_if, 32'hFFFF_FFFC);
      step(32'h0000_3000, 1'b0, 1'b0, 1'b0);
      cmp("wrap.pc_id", pc_id,  32'h0000_0000);
      cmp("wrap.pc8",   pc8_id, 32'h0000_0004);

      // reset during stall
      step(32'h0000_3010, 1'b0, 1'b0, 1'b0);
      step(32'h0000_3020, 1'b1, 1'b0, 1'b0);
      cmp("rs.pre", pc_if, 32'h0000_3010);
      step(32'h0000_5000, 1'b1, 1'b0, 1'b1);
      cmp("rs.pc_if", pc_if,    32'h0000_3000);
      cmp("rs.valid", {31'd0, valid_id}, 32'd0);
      cmp("rs.cnt",   fetch_cnt, 32'd0);
      cmp("rs.instr", instr_id, 32'd0);

      // reset during flush, then first fetch after release
      step(32'h0000_3100, 1'b0, 1'b1, 1'b1);
      cmp("rf.pc_if", pc_if, 32'h0000_3000);
      step(32'h0000_3004, 1'b0, 1'b0, 1'b0);
      cmp("rf.instr", instr_id, 32'h0000_3000);
      cmp("rf.cnt",   fetch_cnt, 32'd1);

      // mixed traffic: periodic stalls, flushes and misaligned targets
      for (int i = 0; i < 24; i++) begin
         step((i % 6 == 4) ? (m_pc + 32'd6) : (m_pc + 32'd4),
              (i % 5 == 2), (i % 7 == 3), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/if_id_fetch_unit.md
Name: if_id_fetch_unit

Overview:
- Consumer end of the next-PC path: holds the fetch PC register and the IF/ID pipeline register of the 5-stage MIPS core.
- Accepts the next-PC value each cycle; drives the instruction-memory address.
- Returns the ID-stage instruction and link PCs that the next-PC logic and the branch/jump decode consume.
- Owns stall hold, ID flush/bubble insertion and a fetch counter.

Parameters:
- RESET_PC, 32'h0000_3000, fetch PC value after reset.
- IM_BASE, 32'h0000_3000, lowest legal instruction address. Used only with the optional feature.
- IM_WORDS, 1024, number of 32-bit words in instruction memory. Used only with the optional feature.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- npc  input  32  next fetch PC from the next-PC logic.
- stall  input  1  hazard stall; holds the PC and IF/ID.
- flush_id  input  1  replaces the IF/ID contents with a bubble.
- instr_if  input  32  instruction word read combinationally from IM at pc_if.
- pc_if  output  32  current fetch PC; drives the IM address and the next-PC sequential input.
- instr_id  output  32  instruction in ID.
- pc_id  output  32  PC+4 of the instruction in ID; the branch/jump base.
- pc8_id  output  32  PC+8 of the instruction in ID; the jal link value.
- valid_id  output  1  ID holds a real fetched instruction. 0 means bubble.
- fetch_cnt  output  32  number of accepted fetches.
- adel_id  output  1  ID instruction came from an illegal fetch address. Tied 0 without the optional feature.

Behaviour:
- Reset (reset=1 at an edge):
  - pc_if=RESET_PC.
  - instr_id=0, pc_id=0, pc8_id=0, valid_id=0.
  - fetch_cnt=0, adel_id=0.
  - Reset overrides stall and flush_id.
- Priority at each edge: reset > stall > flush_id > normal advance.
- Normal advance (stall=0, flush_id=0):
  - pc_if <= {npc[31:2],2'b00}.
  - instr_id <= instr_if.
  - pc_id <= pc_if+4.
  - pc8_id <= pc_if+8.
  - valid_id <= 1.
  - fetch_cnt <= fetch_cnt+1.
- Stall (stall=1):
  - All registers hold, including fetch_cnt.
  - flush_id is ignored while stall=1. The requester keeps flush_id high until stall drops.
- Flush (stall=0, flush_id=1):
  - pc_if <= {npc[31:2],2'b00}; the PC still advances.
  - IF/ID loads a bubble: instr_id=0 (sll nop), pc_id=0, pc8_id=0, valid_id=0, adel_id=0.
  - fetch_cnt does not increment.
- Latency:
  - npc appears on pc_if one cycle after it is presented.
  - The instruction at pc_if appears on instr_id one cycle later.
  - Branch/jump targets resolved in ID take effect at the next edge. The instruction fetched in that cycle is the delay slot and is not flushed by this block.
- Arithmetic:
  - All PC sums are 32-bit modulo 2^32. pc_if=32'hFFFF_FFFC gives pc_id=0 and pc8_id=4.
  - fetch_cnt wraps from 32'hFFFF_FFFF to 0.
- npc[1:0] is discarded without the optional feature; PCs are always word aligned.
- Reset asserted mid-stall or mid-flush returns all state to reset values on that edge. The first fetch after deassertion is at RESET_PC.
- X on stall or flush_id outside reset is an error. Verification asserts against it; the RTL requires no specific behaviour.

Optional Feature:
- Macro: FETCH_ADDR_CHECK_EN.
- When defined:
  - The fetch address is illegal if npc[1:0]!=0, npc<IM_BASE, or npc>=IM_BASE+4*IM_WORDS.
  - An illegal npc is still loaded into pc_if, with low bits forced to 0. A flag bit is registered alongside it.
  - On the next advance, adel_id <= flag and instr_id <= 0 in place of instr_if.
  - valid_id=1 and fetch_cnt increments.
  - Stall holds adel_id; flush clears it.
- When undefined: no check logic; adel_id is constant 0.

Test Plan:
- Reset then release, npc=pc_if+4 each cycle, IM returns word = address → cycle 1: pc_if=3000. Cycle 2: pc_if=3004, instr_id=3000, pc_id=3004, pc8_id=3008, valid_id=1, fetch_cnt=1.
- stall=1 for 3 cycles with npc=4000 → pc_if, instr_id, pc_id and fetch_cnt unchanged across all 3 edges. First edge after release: pc_if=4000.
- stall=1 and flush_id=1 together, then stall=0 with flush_id=1 → first edge holds everything. Second edge: pc_if=npc, instr_id=0, valid_id=0, fetch_cnt unchanged.
- npc=3003 → pc_if=3000. With FETCH_ADDR_CHECK_EN: adel_id=1 and instr_id=0 on the next edge. Without it: adel_id=0.
- pc_if=FFFF_FFFC, normal advance → pc_id=0, pc8_id=4. With fetch_cnt preloaded to FFFF_FFFF via a run, it becomes 0.
- reset=1 asserted during stall=1 with pc_if=3010 → next edge: pc_if=3000, valid_id=0, fetch_cnt=0, instr_id=0.
